trig_pueo_msg_scheduler: RTL and testbench

TRIG_PUEO_MSG_SCHEDULER -- requirements
Module: trig_pueo_msg_scheduler

---
 rtl/trig_pueo_msg_scheduler.sv | 164 ++++++++++++++++
 tb/tb_trig_pueo_msg_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_pueo_msg_scheduler.sv
// Builds one 32-bit link message per phase strobe from trigger, PPS, run command and FWU byte stream.
// Latency: message registered one clock after the phase; run pulses BASE_DLY+rundly_i clocks after their phase; FWU backpressures when full.
module trig_pueo_msg_scheduler #(
   parameter int NUM_LINKS = 2,
   parameter int FWU_DEPTH = 16,
   parameter int BASE_DLY  = 34
) (
   input  logic                          sysclk_i,
   input  logic                          sysclk_rst_i,
   input  logic                          sysclk_phase_i,
   input  logic                          sysclk_sync_i,
   input  logic                          pps_i,
   input  logic                          en_pps_i,
   input  logic [NUM_LINKS-1:0]          link_en_i,
   input  logic [3:0]                    rundly_i,
   input  logic [1:0]                    s_runcmd_tdata,
   input  logic                          s_runcmd_tvalid,
   output logic                          s_runcmd_tready,
   input  logic [31:0]                   s_fwu_tdata,
   input  logic                          s_fwu_tvalid,
   input  logic                          s_fwu_tlast,
   output logic                          s_fwu_tready,
   input  logic [14:0]                   s_trig_tdata,
   input  logic                          s_trig_tvalid,
   output logic                          s_trig_tready,
   output logic [32*NUM_LINKS-1:0]       command_o,
   output logic [$clog2(FWU_DEPTH):0]    fwu_count_o,
   output logic                          runrst_o,
   output logic                          runstop_o
);
   localparam int CW     = $clog2(FWU_DEPTH);
   localparam int SR_LEN = BASE_DLY + 15;

   logic [32:0]           fifo_mem [FWU_DEPTH];
   logic [CW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW:0]           count_q, count_d;
   logic [1:0]            byte_idx_q;
   logic                  mark_pending_q, mark_buf_q;
   logic                  runcmd_pending_q;
   logic [1:0]            runcmd_q;
   logic                  pps_pending_q, pps_prev_q;
   logic [SR_LEN-1:0]     rst_sr_q, stop_sr_q;
   logic [32*NUM_LINKS-1:0] command_q;

   logic        push, pop, send_mark, send_byte, send_rc, send_pps, pps_cur, pps_rise;
   logic [32:0] head;
   logic [7:0]  head_byte;
   logic [1:0]  m1_type;
   logic [7:0]  m1_data;
   logic [31:0] msg;

   assign s_trig_tready   = sysclk_phase_i;
   assign s_runcmd_tready = ~runcmd_pending_q | sysclk_rst_i;
   // Depth is a power of two, so the count MSB alone flags a full FIFO.
   assign s_fwu_tready    = ~sysclk_rst_i & ~count_q[CW];
   assign fwu_count_o     = count_q;
   assign command_o       = command_q;

   assign push      = s_fwu_tvalid & s_fwu_tready;
   assign head      = fifo_mem[rd_ptr_q];
   assign send_mark = sysclk_phase_i & mark_pending_q;
   assign send_byte = sysclk_phase_i & ~mark_pending_q & (count_q != '0);
   assign pop       = send_byte & (byte_idx_q == 2'd3);
   assign send_rc   = sysclk_phase_i & sysclk_sync_i & runcmd_pending_q;
   assign send_pps  = sysclk_phase_i & pps_pending_q;
   assign pps_cur   = pps_i & en_pps_i;
   assign pps_rise  = pps_cur & ~pps_prev_q;

   always_comb begin
      head_byte = head[7:0];
      case (byte_idx_q)
         2'd1:    head_byte = head[15:8];
         2'd2:    head_byte = head[23:16];
         2'd3:    head_byte = head[31:24];
         default: head_byte = head[7:0];
      endcase
   end

   always_comb begin
      m1_type = 2'b00;
      m1_data = 8'h00;
      if (send_mark) begin
         m1_data = {6'b0, 1'b1, mark_buf_q};
      end else if (send_byte) begin
         m1_type = 2'b11;
         m1_data = head_byte;
      end
      msg = {~(send_rc | send_mark | send_byte | send_pps), send_pps, 2'b00,
             (send_rc ? runcmd_q : 2'b00), m1_type, m1_data, s_trig_tvalid, s_trig_tdata};
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge sysclk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= {s_fwu_tlast, s_fwu_tdata};
   end

   always_ff @(posedge sysclk_i) begin
      if (sysclk_rst_i) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         byte_idx_q       <= 2'd0;
         mark_pending_q   <= 1'b0;
         mark_buf_q       <= 1'b0;
         runcmd_pending_q <= 1'b0;
         runcmd_q         <= 2'b00;
         pps_pending_q    <= 1'b0;
         pps_prev_q       <= 1'b0;
         rst_sr_q         <= '0;
         stop_sr_q        <= '0;
         command_q        <= {NUM_LINKS{32'h8000_0000}};
      end else begin
         count_q    <= count_d;
         pps_prev_q <= pps_cur;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (send_byte) byte_idx_q <= byte_idx_q + 1'b1;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (head[32]) mark_pending_q <= 1'b1;
         end else if (send_mark) begin
            mark_pending_q <= 1'b0;
            mark_buf_q     <= ~mark_buf_q;
         end
         if (s_runcmd_tvalid && s_runcmd_tready && s_runcmd_tdata != 2'b00) begin
            runcmd_pending_q <= 1'b1;
            runcmd_q         <= s_runcmd_tdata;
         end else if (send_rc) begin
            runcmd_pending_q <= 1'b0;
         end
         // A new edge coinciding with a send re-arms for the next phase.
         if (pps_rise)      pps_pending_q <= 1'b1;
         else if (send_pps) pps_pending_q <= 1'b0;
         rst_sr_q  <= {rst_sr_q[SR_LEN-2:0],  send_rc & (runcmd_q == 2'd2)};
         stop_sr_q <= {stop_sr_q[SR_LEN-2:0], send_rc & (runcmd_q == 2'd3)};
         if (sysclk_phase_i) begin
            for (int n = 0; n < NUM_LINKS; n++)
               command_q[32*n +: 32] <= link_en_i[n] ? msg : 32'h8000_0000;
         end
      end
   end

   always_comb begin
      runrst_o  = 1'b0;
      runstop_o = 1'b0;
      for (int k = 0; k < SR_LEN; k++) begin
         if (k == BASE_DLY + int'(rundly_i) - 1) begin
            runrst_o  = rst_sr_q[k];
            runstop_o = stop_sr_q[k];
         end
      end
      if (sysclk_rst_i) begin
         runrst_o  = 1'b0;
         runstop_o = 1'b0;
      end
   end
endmodule

// File: tb/tb_trig_pueo_msg_scheduler.sv
// Directed bench for trig_pueo_msg_scheduler with hand-computed expected messages.
module tb_trig_pueo_msg_scheduler;
   logic        clk = 1'b0;
   logic        rst, phase, sync, pps, en_pps;
   logic [1:0]  link_en;
   logic [3:0]  rundly;
   logic [1:0]  rc_tdata;
   logic        rc_tvalid, rc_tready;
   logic [31:0] fwu_tdata;
   logic        fwu_tvalid, fwu_tlast, fwu_tready;
   logic [14:0] trig_tdata;
   logic        trig_tvalid, trig_tready;
   logic [63:0] command;
   logic [4:0]  fwu_count;
   logic        runrst, runstop;

   int n_cmp = 0;
   int n_err = 0;

   trig_pueo_msg_scheduler #(.NUM_LINKS(2), .FWU_DEPTH(16), .BASE_DLY(34)) dut (
      .sysclk_i(clk), .sysclk_rst_i(rst), .sysclk_phase_i(phase), .sysclk_sync_i(sync),
      .pps_i(pps), .en_pps_i(en_pps), .link_en_i(link_en), .rundly_i(rundly),
      .s_runcmd_tdata(rc_tdata), .s_runcmd_tvalid(rc_tvalid), .s_runcmd_tready(rc_tready),
      .s_fwu_tdata(fwu_tdata), .s_fwu_tvalid(fwu_tvalid), .s_fwu_tlast(fwu_tlast),
      .s_fwu_tready(fwu_tready),
      .s_trig_tdata(trig_tdata), .s_trig_tvalid(trig_tvalid), .s_trig_tready(trig_tready),
      .command_o(command), .fwu_count_o(fwu_count), .runrst_o(runrst), .runstop_o(runstop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic phase_tick();
      phase = 1'b1;
      tick();
      phase = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic last);
      fwu_tdata  = d;
      fwu_tlast  = last;
      fwu_tvalid = 1'b1;
      tick();
      fwu_tvalid = 1'b0;
   endtask

   task automatic runcmd(input logic [1:0] c);
      rc_tdata  = c;
      rc_tvalid = 1'b1;
      tick();
      rc_tvalid = 1'b0;
   endtask

   task automatic send_word(input string tag, input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         phase_tick();
         chk(tag, 64'(command[31:0]), 64'({8'h03, w[8*b +: 8], 16'h0000}));
      end
   endtask

   // Checks the pulse is absent for the D-1 cycles after the phase and present on cycle D.
   task automatic pulse_check(input string tag, input int d, input bit stop);
      logic early;
      early = stop ? runstop : runrst;
      for (int i = 0; i < d - 2; i++) begin
         tick();
         early = early | (stop ? runstop : runrst);
      end
      chk({tag, "_early"}, 64'(early), 64'(0));
      tick();
      chk({tag, "_on"}, 64'(stop ? runstop : runrst), 64'(1));
      tick();
      chk({tag, "_off"}, 64'(stop ? runstop : runrst), 64'(0));
   endtask

   initial begin
      logic [7:0] bv;
      int         pps_cnt;
      logic       pps31;

      rst = 1'b1; phase = 1'b0; sync = 1'b0; pps = 1'b0; en_pps = 1'b0;
      link_en = 2'b11; rundly = 4'd0; rc_tdata = 2'b00; rc_tvalid = 1'b0;
      fwu_tdata = 32'h0; fwu_tvalid = 1'b0; fwu_tlast = 1'b0;
      trig_tdata = 15'h0; trig_tvalid = 1'b0;

      ticks(2);
      chk("rst_cmd", command, 64'h80000000_80000000);
      chk("rst_runrst", 64'(runrst), 64'(0));
      chk("rst_runstop", 64'(runstop), 64'(0));
      chk("rst_rc_rdy", 64'(rc_tready), 64'(1));
      chk("rst_fwu_rdy", 64'(fwu_tready), 64'(0));
      chk("rst_count", 64'(fwu_count), 64'(0));
      rst = 1'b0;
      tick();
      chk("fwu_rdy_after_rst", 64'(fwu_tready), 64'(1));

      // Trigger pass-through with link 1 disabled.
      link_en = 2'b01; trig_tvalid = 1'b1; trig_tdata = 15'h1234; phase = 1'b1;
      #1;
      chk("trig_rdy_hi", 64'(trig_tready), 64'(1));
      tick();
      phase = 1'b0;
      #1;
      chk("trig_rdy_lo", 64'(trig_tready), 64'(0));
      chk("trig_cmd", command, 64'h80000000_80009234);
      trig_tvalid = 1'b0; trig_tdata = 15'h0; link_en = 2'b11;

      // FWU byte stream with phase every 4 clocks, then the end-of-packet mark.
      push(32'h44332211, 1'b1);
      chk("fwu_count1", 64'(fwu_count), 64'(1));
      phase_tick();
      chk("fwu_b0", command, 64'h03110000_03110000);
      chk("fwu_count_partial", 64'(fwu_count), 64'(1));
      ticks(3);
      chk("fwu_hold", 64'(command[31:0]), 64'h03110000);
      phase_tick(); chk("fwu_b1", 64'(command[31:0]), 64'h03220000); ticks(3);
      phase_tick(); chk("fwu_b2", 64'(command[31:0]), 64'h03330000); ticks(3);
      phase_tick(); chk("fwu_b3", 64'(command[31:0]), 64'h03440000);
      chk("fwu_count0", 64'(fwu_count), 64'(0));
      ticks(3);
      phase_tick(); chk("fwu_mark0", 64'(command[31:0]), 64'h00020000); ticks(3);
      phase_tick(); chk("fwu_idle", 64'(command[31:0]), 64'h80000000);
      push(32'hDDCCBBAA, 1'b1);
      send_word("fwu_w2", 32'hDDCCBBAA);
      phase_tick(); chk("fwu_mark1", 64'(command[31:0]), 64'h00030000);

      // Run reset command held until sync, delay 34+3.
      rundly = 4'd3;
      runcmd(2'd2);
      chk("rc_rdy_pending", 64'(rc_tready), 64'(0));
      for (int i = 0; i < 3; i++) begin
         phase_tick();
         chk("rc_nosync", 64'(command[31:0]), 64'h80000000);
         ticks(3);
      end
      sync = 1'b1;
      phase_tick();
      sync = 1'b0;
      chk("rc_sent", 64'(command[31:0]), 64'h08000000);
      chk("rc_rdy_free", 64'(rc_tready), 64'(1));
      pulse_check("runrst", 37, 1'b0);
      chk("rc_no_stop", 64'(runstop), 64'(0));

      // Zero command is swallowed.
      runcmd(2'd0);
      chk("rc0_rdy", 64'(rc_tready), 64'(1));
      sync = 1'b1;
      phase_tick();
      sync = 1'b0;
      chk("rc0_cmd", 64'(command[31:0]), 64'h80000000);

      // PPS held over five phases gives one message; disabled gives none.
      en_pps = 1'b1; pps_cnt = 0; pps31 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pps = 1'b1; phase = (i % 4 == 0);
         tick();
         if (i % 4 == 0 && command[30]) begin pps_cnt++; pps31 = command[31]; end
      end
      phase = 1'b0; pps = 1'b0; tick();
      chk("pps_count_en", 64'(pps_cnt), 64'(1));
      chk("pps_b31", 64'(pps31), 64'(0));
      en_pps = 1'b0; pps_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         pps = 1'b1; phase = (i % 4 == 0);
         tick();
         if (i % 4 == 0 && command[30]) pps_cnt++;
      end
      phase = 1'b0; pps = 1'b0; tick();
      chk("pps_count_dis", 64'(pps_cnt), 64'(0));

      // Fill to full, then pop with a simultaneous push.
      fwu_tvalid = 1'b1; fwu_tlast = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bv = 8'h10 + 8'(i);
         fwu_tdata = {4{bv}};
         tick();
      end
      fwu_tvalid = 1'b0;
      chk("full_count", 64'(fwu_count), 64'(16));
      chk("full_rdy", 64'(fwu_tready), 64'(0));
      send_word("full_w0", 32'h10101010);
      chk("full_count15", 64'(fwu_count), 64'(15));
      ticks(1);
      phase_tick(); phase_tick(); phase_tick();
      phase = 1'b1; fwu_tvalid = 1'b1; fwu_tdata = 32'h5A5A5A5A;
      tick();
      phase = 1'b0; fwu_tvalid = 1'b0;
      chk("simul_b3", 64'(command[31:0]), 64'h03110000);
      chk("simul_count", 64'(fwu_count), 64'(15));
      for (int w = 2; w < 16; w++) begin
         bv = 8'h10 + 8'(w);
         send_word("drain", {4{bv}});
      end
      send_word("drain_last", 32'h5A5A5A5A);
      chk("drain_count", 64'(fwu_count), 64'(0));

      // Reset in mid-word with mark_buf set.
      push(32'h04030201, 1'b1);
      send_word("pre_rst_w", 32'h04030201);
      phase_tick(); chk("pre_rst_mark", 64'(command[31:0]), 64'h00020000);
      push(32'h44332211, 1'b1);
      phase_tick(); chk("mid_b0", 64'(command[31:0]), 64'h03110000);
      phase_tick(); chk("mid_b1", 64'(command[31:0]), 64'h03220000);
      rst = 1'b1;
      tick();
      chk("mid_rst_cmd", command, 64'h80000000_80000000);
      chk("mid_rst_count", 64'(fwu_count), 64'(0));
      chk("mid_rst_rdy", 64'(fwu_tready), 64'(0));
      rst = 1'b0;
      tick();
      phase_tick(); chk("post_rst_nomark", 64'(command[31:0]), 64'h80000000);
      push(32'hCCBBAA99, 1'b1);
      send_word("post_rst_w", 32'hCCBBAA99);
      phase_tick(); chk("post_rst_mark", 64'(command[31:0]), 64'h00020000);

      // Runcmd, PPS and FWU byte in one message; run stop at base delay.
      rundly = 4'd0;
      push(32'h11223377, 1'b0);
      runcmd(2'd3);
      en_pps = 1'b1; pps = 1'b1;
      tick();
      sync = 1'b1;
      phase_tick();
      sync = 1'b0;
      chk("combo_cmd", 64'(command[31:0]), 64'h4F770000);
      pulse_check("runstop", 34, 1'b1);
      pps = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
